// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the four-digit seven-segment display path.
// The frame layout matches the number_counting output bus.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;
  localparam int NUMBER_W   = NUM_DIGITS * SEG_W;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int BRIGHT_W   = 4;

  localparam logic [SEG_W-1:0]      SEG_BLANK  = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = 4'hF;
  localparam logic [BRIGHT_W-1:0]   BRIGHT_MAX = 4'hF;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_ON,
    ST_OFF
  } scan_state_e;

  // Lit cycles for a slot: the usable span scaled by (level+1)/16.
  function automatic int unsigned calc_on_len(input int unsigned span,
                                              input logic [BRIGHT_W-1:0] level);
    return (span * (32'(level) + 32'd1)) >> BRIGHT_W;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot sequencer: slot counter, brightness latch, BLANK/ON/OFF machine and digit index.
// Outputs are next-state values so the caller can register a same-cycle decode.
module seg_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_PERIOD_CYCLES = 100000,
  parameter int DEAD_CYCLES         = 500
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [BRIGHT_W-1:0] brightness_i,
  output scan_state_e         state_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                frame_load_o
);

  localparam int          CNT_W    = $clog2(DIGIT_PERIOD_CYCLES);
  localparam int unsigned LIT_SPAN = int'(DIGIT_PERIOD_CYCLES - DEAD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LEN  = CNT_W'(DEAD_CYCLES);

  scan_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic                run_q, run_d;
  logic [CNT_W-1:0]    on_len;
  logic [CNT_W-1:0]    on_last;

  assign on_len  = CNT_W'(calc_on_len(LIT_SPAN, bright_q));
  assign on_last = DEAD_LEN + on_len - CNT_W'(1);

  // run_q holds the first edge after reset at counter 0 so it can act as the slot-0 start.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      bright_q <= BRIGHT_MAX;
      state_q  <= ST_BLANK;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      bright_q <= bright_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first; a path without assignment would infer a latch.
    run_d    = 1'b1;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    bright_d = bright_q;
    if (!run_q) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_d == '0) bright_d = brightness_i;
  end

  always_comb begin
    state_d = state_q;
    if (!run_q || cnt_q == CNT_LAST) begin
      state_d = ST_BLANK;
    end else begin
      unique case (state_q)
        ST_BLANK: if (cnt_q == DEAD_LAST) state_d = ST_ON;
        ST_ON:    if (cnt_q == on_last)   state_d = ST_OFF;
        ST_OFF:   state_d = ST_OFF;
        default:  state_d = ST_BLANK;
      endcase
    end
  end

  always_comb begin
    state_o      = state_d;
    idx_o        = idx_d;
    frame_load_o = (cnt_d == '0) && (idx_d == '0);
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Four-digit common-anode scan driver: per-scan frame snapshot, dead-time blanking,
// brightness duty and per-digit enables, all outputs registered.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_PERIOD_CYCLES = 100000,
  parameter int DEAD_CYCLES         = 500
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [NUMBER_W-1:0]   number_in,
  input  logic [NUM_DIGITS-1:0] digit_enable_in,
  input  logic [BRIGHT_W-1:0]   brightness_in,
  output logic [NUM_DIGITS-1:0] anode_out,
  output logic [SEG_W-1:0]      segment_out,
  output logic [IDX_W-1:0]      digit_index_out
);

  scan_state_e      slot_state;
  logic [IDX_W-1:0] slot_idx;
  logic             frame_load;

  logic [NUM_DIGITS-1:0][SEG_W-1:0] frame_q, frame_d;
  logic [NUM_DIGITS-1:0]            anode_q, anode_d;
  logic [SEG_W-1:0]                 seg_q, seg_d;
  logic [IDX_W-1:0]                 idx_q;

  seg_slot_timer #(
    .DIGIT_PERIOD_CYCLES (DIGIT_PERIOD_CYCLES),
    .DEAD_CYCLES         (DEAD_CYCLES)
  ) u_timer (
    .clk_i        (clk_in),
    .rst_n_i      (rst_n_in),
    .brightness_i (brightness_in),
    .state_o      (slot_state),
    .idx_o        (slot_idx),
    .frame_load_o (frame_load)
  );

  // Decode uses the timer's next-state so the registered outputs line up with the slot.
  always_comb begin
    frame_d = frame_load ? number_in : frame_q;
    anode_d = ANODE_OFF;
    seg_d   = SEG_BLANK;
    if (slot_state == ST_ON && digit_enable_in[slot_idx]) begin
      anode_d[slot_idx] = 1'b0;
      seg_d             = frame_q[slot_idx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      // NOTE: the frame is a plain register bank, reset to all ones so it reads as blank, never X.
      frame_q <= {NUM_DIGITS{SEG_BLANK}};
      anode_q <= ANODE_OFF;
      seg_q   <= SEG_BLANK;
      idx_q   <= '0;
    end else begin
      frame_q <= frame_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      idx_q   <= slot_idx;
    end
  end

  assign anode_out       = anode_q;
  assign segment_out     = seg_q;
  assign digit_index_out = idx_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver at 40-cycle slots with 8 dead cycles,
// plus directed checks on lit lengths, anode order, frame snapshot and reset.
module tb_seven_seg_scan_driver;

  localparam int P = 40;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n_in;
  logic [27:0] number_in;
  logic [3:0]  digit_enable_in;
  logic [3:0]  brightness_in;
  logic [3:0]  anode_out;
  logic [6:0]  segment_out;
  logic [1:0]  digit_index_out;

  seven_seg_scan_driver #(
    .DIGIT_PERIOD_CYCLES (P),
    .DEAD_CYCLES         (D)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n_in),
    .number_in       (number_in),
    .digit_enable_in (digit_enable_in),
    .brightness_in   (brightness_in),
    .anode_out       (anode_out),
    .segment_out     (segment_out),
    .digit_index_out (digit_index_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] idx;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // Active-low gfedcba patterns; frame word is {thousands, hundreds, tens, ones}.
  localparam logic [27:0] NUM_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] NUM_5678 = {7'h12, 7'h02, 7'h78, 7'h00};

  // Reference model state
  bit          m_run;
  int          m_pos, m_idx, m_b;
  logic [27:0] m_frame;

  // Directed observation state
  int         cyc = 0;
  int         lit_cnt;
  logic [3:0] lit_an;
  logic [6:0] lit_seg;
  logic [1:0] prev_idx = 2'd0;
  int         wraps = 0;
  int         last_wrap = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cyc, got, exp);
    end
  endtask

  // Predict the outputs after the coming edge from the inputs applied now.
  task automatic model_edge();
    exp_t e;
    bit   lit;
    if (!rst_n_in) begin
      m_run = 1'b0; m_pos = 0; m_idx = 0; m_b = 15; m_frame = '1;
    end else if (!m_run) begin
      m_run = 1'b1; m_pos = 0; m_idx = 0; m_b = int'(brightness_in); m_frame = number_in;
    end else begin
      m_pos++;
      if (m_pos == P) begin
        m_pos = 0;
        m_idx = (m_idx + 1) % 4;
        if (m_idx == 0) m_frame = number_in;
      end
      if (m_pos == 0) m_b = int'(brightness_in);
    end
    lit   = m_run && m_pos >= D && m_pos < D + 2 * (m_b + 1) && digit_enable_in[m_idx];
    e.an  = lit ? ~(4'b0001 << m_idx) : 4'hF;
    e.seg = lit ? m_frame[m_idx*7 +: 7] : 7'h7F;
    e.idx = 2'(m_idx);
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("anode", 32'(anode_out), 32'(e.an));
      check("segment", 32'(segment_out), 32'(e.seg));
      check("index", 32'(digit_index_out), 32'(e.idx));
    end
    check("one_anode", 32'($countones(~anode_out) <= 1), 32'd1);
    if (anode_out !== 4'hF) begin
      lit_cnt++;
      lit_an  = anode_out;
      lit_seg = segment_out;
    end
    if (prev_idx == 2'd3 && digit_index_out == 2'd0) begin
      wraps++;
      if (last_wrap >= 0) check("wrap_period", 32'(cyc - last_wrap), 32'(4 * P));
      last_wrap = cyc;
    end
    prev_idx = digit_index_out;
  endtask

  task automatic run_slot(input string tag, input int want_lit);
    lit_cnt = 0;
    lit_an  = 4'hF;
    lit_seg = 7'h7F;
    repeat (P) cycle();
    check(tag, 32'(lit_cnt), 32'(want_lit));
  endtask

  logic [3:0] an_order [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

  initial begin
    rst_n_in        = 1'b0;
    number_in       = NUM_1234;
    digit_enable_in = 4'hF;
    brightness_in   = 4'hF;

    repeat (3) cycle();
    check("rst_anode", 32'(anode_out), 32'hF);
    check("rst_seg", 32'(segment_out), 32'h7F);

    // Full brightness scan of "1234"
    rst_n_in = 1'b1;
    for (int s = 0; s < 4; s++) begin
      run_slot("on_len_b15", 32);
      check("anode_order", 32'(lit_an), 32'(an_order[s]));
      check("digit_seg", 32'(lit_seg), 32'(seg_1234[s]));
    end

    // Brightness 0, then 7 mid-slot
    brightness_in = 4'd0;
    run_slot("on_len_b0", 2);
    lit_cnt = 0;
    repeat (20) cycle();
    brightness_in = 4'd7;
    repeat (P - 20) cycle();
    check("on_len_keep_b0", 32'(lit_cnt), 32'd2);
    run_slot("on_len_b7", 16);
    brightness_in = 4'hF;
    run_slot("on_len_back_b15", 32);

    // Frame snapshot: change number while slot 2 is lit
    run_slot("snap_slot0", 32);
    check("snap_seg0", 32'(lit_seg), 32'h19);
    run_slot("snap_slot1", 32);
    check("snap_seg1", 32'(lit_seg), 32'h30);
    lit_cnt = 0;
    repeat (10) cycle();
    number_in = NUM_5678;
    repeat (P - 10) cycle();
    check("snap_old_seg2", 32'(lit_seg), 32'h24);
    run_slot("snap_slot3", 32);
    check("snap_old_seg3", 32'(lit_seg), 32'h79);
    run_slot("snap_slot0_new", 32);
    check("snap_new_seg0", 32'(lit_seg), 32'h00);
    run_slot("snap_slot1_new", 32);
    check("snap_new_seg1", 32'(lit_seg), 32'h78);

    // Per-digit enables 0101, starting at slot 2
    digit_enable_in = 4'b0101;
    run_slot("en_slot2", 32);
    run_slot("en_slot3_dark", 0);
    run_slot("en_slot0", 32);
    run_slot("en_slot1_dark", 0);
    digit_enable_in = 4'hF;

    // Reset in the middle of slot 2's ON phase
    repeat (12) cycle();
    rst_n_in = 1'b0;
    cycle();
    check("midrst_anode", 32'(anode_out), 32'hF);
    check("midrst_seg", 32'(segment_out), 32'h7F);
    check("midrst_index", 32'(digit_index_out), 32'd0);
    repeat (2) cycle();
    rst_n_in = 1'b1;
    lit_cnt = 0;
    repeat (D) cycle();
    check("post_rst_blank", 32'(lit_cnt), 32'd0);
    cycle();
    check("post_rst_on_start", 32'(lit_cnt), 32'd1);
    repeat (P - D - 1) cycle();

    // Three full scans with input changes at arbitrary points
    wraps     = 0;
    last_wrap = -1;
    for (int i = 0; i < 12 * P; i++) begin
      if (i == 130) number_in = 28'($urandom);
      if (i == 200) brightness_in = 4'($urandom_range(0, 15));
      if (i == 330) number_in = 28'($urandom);
      cycle();
    end
    check("wrap_count", 32'(wraps), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
